// File: rtl/pll_clk_manager.sv
// -----------------------------------------------------------------------------
// pll_clk_manager
//
// Sequences a PLL out of reset, qualifies its lock flag, and releases the
// downstream reset and per-channel clock-enable pulses once lock has been
// stable for long enough. Loss of lock during operation re-resets the PLL and
// is counted. A PLL that never locks is retried forever, and a sticky error
// flag records that a timeout happened.
//
// Ports
//   refclk      in   single clock for all logic
//   rst         in   asynchronous active-low reset
//   pll_locked  in   raw, asynchronous lock flag from the PLL
//   div         in   per-channel divisor, channel k in [k*DIV_W +: DIV_W]
//   clr_err     in   synchronous pulse clearing lock_err
//   pll_rst     out  active-high reset to the PLL
//   locked      out  qualified lock indication (high only in RUN)
//   rst_out_n   out  active-low downstream reset (released only in RUN)
//   clk_en      out  per-channel single-cycle enable pulses, period div_k+1
//   relock_cnt  out  saturating count of lock losses seen while running
//   lock_err    out  sticky flag set by a lock timeout
// -----------------------------------------------------------------------------
module pll_clk_manager #(
    parameter int NUM_CH       = 2,
    parameter int DIV_W        = 8,
    parameter int RST_PULSE    = 16,
    parameter int LOCK_STABLE  = 256,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int CNT_W        = 8
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic [NUM_CH*DIV_W-1:0] div,
    input  logic                    clr_err,
    output logic                    pll_rst,
    output logic                    locked,
    output logic                    rst_out_n,
    output logic [NUM_CH-1:0]       clk_en,
    output logic [CNT_W-1:0]        relock_cnt,
    output logic                    lock_err
);

    typedef enum logic [1:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    // One shared timer serves the three timed states, so it is sized for the
    // longest of them.
    localparam int TMR_MAX_A = (RST_PULSE > LOCK_STABLE) ? RST_PULSE : LOCK_STABLE;
    localparam int TMR_MAX   = (TMR_MAX_A > LOCK_TIMEOUT) ? TMR_MAX_A : LOCK_TIMEOUT;
    localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_PULSE - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RELOCK_MAX   = '1;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             lk_meta, lk_s;
    logic             timeout;
    logic             lost;
    logic             run_entry;
    logic             run_stay;

    // Two-flop synchroniser; only lk_s is ever looked at by the FSM.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can
        // leave one unassigned and infer a latch.
        state_nxt = state;
        tmr_nxt   = tmr;
        timeout   = 1'b0;
        lost      = 1'b0;
        unique case (state)
            RESET_PLL: begin
                if (tmr == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_nxt = STABLE;
                    tmr_nxt   = '0;
                end else if (tmr == TIMEOUT_LAST) begin
                    state_nxt = RESET_PLL;
                    tmr_nxt   = '0;
                    timeout   = 1'b1;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            STABLE: begin
                // Any dropout restarts qualification with a fresh timeout.
                if (!lk_s) begin
                    state_nxt = WAIT_LOCK;
                    tmr_nxt   = '0;
                end else if (tmr == STABLE_LAST) begin
                    state_nxt = RUN;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_nxt = RESET_PLL;
                    tmr_nxt   = '0;
                    lost      = 1'b1;
                end
            end
            default: begin
                state_nxt = RESET_PLL;
                tmr_nxt   = '0;
            end
        endcase
    end

    assign run_entry = (state != RUN) && (state_nxt == RUN);
    assign run_stay  = (state == RUN) && (state_nxt == RUN);

    // Outputs are registered from the next state so they line up with the
    // state register and drop in the very cycle RUN is left.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state      <= RESET_PLL;
            tmr        <= '0;
            pll_rst    <= 1'b1;
            locked     <= 1'b0;
            rst_out_n  <= 1'b0;
            relock_cnt <= '0;
            lock_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            pll_rst   <= (state_nxt == RESET_PLL);
            locked    <= (state_nxt == RUN);
            rst_out_n <= (state_nxt == RUN);
            if (lost && (relock_cnt != RELOCK_MAX)) begin
                relock_cnt <= relock_cnt + CNT_W'(1);
            end
            // A timeout wins over a coincident clear.
            if (timeout) begin
                lock_err <= 1'b1;
            end else if (clr_err) begin
                lock_err <= 1'b0;
            end
        end
    end

    // Per-channel dividers. The divisor is latched at RUN entry and at each
    // wrap, so a change on div only takes effect from the next full period.
    // The enable is the registered version of "counter equals divisor".
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DIV_W-1:0] div_k;
        logic [DIV_W-1:0] ch_cnt;
        logic [DIV_W-1:0] ch_div;
        logic             ch_pulse;

        assign div_k     = div[k*DIV_W +: DIV_W];
        assign clk_en[k] = ch_pulse;

        always_ff @(posedge refclk or negedge rst) begin
            if (!rst) begin
                ch_cnt   <= '0;
                ch_div   <= '0;
                ch_pulse <= 1'b0;
            end else if (run_entry) begin
                ch_cnt   <= '0;
                ch_div   <= div_k;
                ch_pulse <= (div_k == '0);
            end else if (run_stay) begin
                if (ch_cnt == ch_div) begin
                    ch_cnt   <= '0;
                    ch_div   <= div_k;
                    ch_pulse <= (div_k == '0);
                end else begin
                    ch_cnt   <= ch_cnt + DIV_W'(1);
                    ch_pulse <= ((ch_cnt + DIV_W'(1)) == ch_div);
                end
            end else begin
                ch_cnt   <= '0;
                ch_pulse <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pll_clk_manager.sv
// -----------------------------------------------------------------------------
// tb_pll_clk_manager
//
// Drives pll_clk_manager with directed lock scenarios followed by randomized
// lock/divisor/clear traffic. A cycle-level behavioural model derives every
// expected output from elapsed-cycle arithmetic and absolute pulse times; a
// compare process checks all outputs on every falling edge, and directed
// sections pin the model with hand-computed latencies and periods.
// -----------------------------------------------------------------------------
module tb_pll_clk_manager;

    localparam int NUM_CH       = 2;
    localparam int DIV_W        = 4;
    localparam int RST_PULSE    = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 32;
    localparam int CNT_W        = 8;
    localparam int RELOCK_SAT   = (1 << CNT_W) - 1;

    logic                    refclk     = 1'b0;
    logic                    rst        = 1'b0;
    logic                    pll_locked = 1'b1;
    logic [NUM_CH*DIV_W-1:0] div        = {4'd3, 4'd0};
    logic                    clr_err    = 1'b0;
    logic                    pll_rst;
    logic                    locked;
    logic                    rst_out_n;
    logic [NUM_CH-1:0]       clk_en;
    logic [CNT_W-1:0]        relock_cnt;
    logic                    lock_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 refclk = ~refclk;

    pll_clk_manager #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .RST_PULSE   (RST_PULSE),
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .div       (div),
        .clr_err   (clr_err),
        .pll_rst   (pll_rst),
        .locked    (locked),
        .rst_out_n (rst_out_n),
        .clk_en    (clk_en),
        .relock_cnt(relock_cnt),
        .lock_err  (lock_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) begin
                $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: phases with elapsed-cycle counts, lock samples
    // delayed through a queue, and each channel's next pulse kept as an
    // absolute cycle number.
    // ------------------------------------------------------------------
    typedef enum {M_PULSE, M_SEARCH, M_QUALIFY, M_RUN} mode_t;

    mode_t m_mode    = M_PULSE;
    int    m_elapsed = 0;
    int    m_cyc     = 0;
    int    m_relock  = 0;
    bit    m_err     = 1'b0;
    bit    m_hist[$];
    int    m_next[NUM_CH];

    always @(posedge refclk or negedge rst) begin : model
        bit lk;
        bit tmo;
        if (!rst) begin
            m_mode    = M_PULSE;
            m_elapsed = 0;
            m_relock  = 0;
            m_err     = 1'b0;
            m_hist    = {1'b0, 1'b0};
            for (int k = 0; k < NUM_CH; k++) m_next[k] = -10;
        end else begin
            lk = m_hist[0];
            void'(m_hist.pop_front());
            m_hist.push_back(pll_locked);
            m_cyc++;
            tmo = 1'b0;
            case (m_mode)
                M_PULSE: begin
                    m_elapsed++;
                    if (m_elapsed == RST_PULSE) begin
                        m_mode    = M_SEARCH;
                        m_elapsed = 0;
                    end
                end
                M_SEARCH: begin
                    if (lk) begin
                        m_mode    = M_QUALIFY;
                        m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == LOCK_TIMEOUT) begin
                            m_mode    = M_PULSE;
                            m_elapsed = 0;
                            tmo       = 1'b1;
                        end
                    end
                end
                M_QUALIFY: begin
                    if (!lk) begin
                        m_mode    = M_SEARCH;
                        m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == LOCK_STABLE) begin
                            m_mode = M_RUN;
                            for (int k = 0; k < NUM_CH; k++)
                                m_next[k] = m_cyc + int'(div[k*DIV_W +: DIV_W]);
                        end
                    end
                end
                default: begin
                    if (!lk) begin
                        m_mode    = M_PULSE;
                        m_elapsed = 0;
                        if (m_relock < RELOCK_SAT) m_relock++;
                    end else begin
                        // The cycle after a pulse starts a new period with
                        // the divisor presented at that moment.
                        for (int k = 0; k < NUM_CH; k++)
                            if (m_cyc - 1 == m_next[k])
                                m_next[k] = m_cyc + int'(div[k*DIV_W +: DIV_W]);
                    end
                end
            endcase
            m_err = tmo || (m_err && !clr_err);
        end
    end

    always @(negedge refclk) begin
        if (cmp_en) begin
            check("pll_rst", pll_rst, m_mode == M_PULSE);
            check("locked", locked, m_mode == M_RUN);
            check("rst_out_n", rst_out_n, m_mode == M_RUN);
            for (int k = 0; k < NUM_CH; k++)
                check($sformatf("clk_en[%0d]", k), clk_en[k], (m_mode == M_RUN) && (m_cyc == m_next[k]));
            check("relock_cnt", relock_cnt, m_relock);
            check("lock_err", lock_err, m_err);
        end
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: actual=timeout expected=finish (t=%0t)", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus and directed checks
    // ------------------------------------------------------------------
    initial begin
        int hi, first_lock, ones0, ones1, j_lock, run_left;
        int offs[$];
        int rises[$];
        logic prev;
        bit ok;

        repeat (3) @(negedge refclk);
        cmp_en = 1'b1;
        check("reset pll_rst", pll_rst, 1);
        check("reset locked", locked, 0);
        check("reset rst_out_n", rst_out_n, 0);
        check("reset clk_en", clk_en, 0);
        check("reset relock_cnt", relock_cnt, 0);
        check("reset lock_err", lock_err, 0);

        // Release with lock already present; index 0 is the falling edge
        // before the first rising edge after release.
        @(posedge refclk);
        #1 rst = 1'b1;
        hi = 0; first_lock = -1; ones0 = 0; ones1 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge refclk);
            if (pll_rst) hi++;
            if (locked && first_lock < 0) first_lock = i;
            if (i >= 13 && i < 25) begin
                ones0 += int'(clk_en[0]);
                ones1 += int'(clk_en[1]);
            end
        end
        check("release pll_rst width", hi, 4);
        check("release lock latency", first_lock, 13);
        check("div0 enables in 12 cycles", ones0, 12);
        check("div3 enables in 12 cycles", ones1, 3);

        // Divisor change mid-period: current period of 4 completes, then 2.
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge refclk);
            if (clk_en[1]) begin ok = 1'b1; break; end
        end
        check("find clk_en[1] pulse", ok, 1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge refclk);
            if (i == 1) div[7:4] = 4'd1;
            if (clk_en[1]) offs.push_back(i);
        end
        check("div change pulse count", offs.size(), 4);
        if (offs.size() >= 3) begin
            check("div change pulse 1", offs[0], 4);
            check("div change pulse 2", offs[1], 6);
            check("div change pulse 3", offs[2], 8);
        end

        // Sub-cycle glitch between edges must be invisible.
        @(posedge refclk);
        #2 pll_locked = 1'b0;
        #2 pll_locked = 1'b1;
        repeat (6) @(negedge refclk);
        check("glitch locked", locked, 1);
        check("glitch relock_cnt", relock_cnt, 0);

        // Three-cycle dropout in RUN.
        @(negedge refclk);
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        check("drop locked", locked, 0);
        check("drop rst_out_n", rst_out_n, 0);
        check("drop clk_en", clk_en, 0);
        check("drop relock_cnt", relock_cnt, 1);
        check("drop pll_rst", pll_rst, 1);
        pll_locked = 1'b1;
        hi = 1;
        for (int j = 0; j < 10; j++) begin
            @(negedge refclk);
            if (pll_rst) hi++;
            else break;
        end
        check("relock pll_rst width", hi, 4);

        // One-cycle dropout at qualification count 5 restarts qualification.
        repeat (4) @(negedge refclk);
        pll_locked = 1'b0;
        @(negedge refclk);
        pll_locked = 1'b1;
        j_lock = -1;
        for (int j = 1; j <= 30; j++) begin
            @(negedge refclk);
            if (locked) begin j_lock = j; break; end
        end
        check("requalify latency", j_lock, 11);

        // Permanent loss: retries every 36 cycles, sticky error and clear.
        @(negedge refclk);
        pll_locked = 1'b0;
        prev = pll_rst;
        for (int c = 1; c <= 200; c++) begin
            @(negedge refclk);
            if (pll_rst && !prev) begin
                rises.push_back(c);
                if (rises.size() == 1) check("lock_err before timeout", lock_err, 0);
                if (rises.size() == 2) check("lock_err after timeout", lock_err, 1);
            end
            prev = pll_rst;
            if (rises.size() == 3) break;
        end
        check("retry rise count", rises.size(), 3);
        if (rises.size() == 3) begin
            check("retry period 1", rises[1] - rises[0], 36);
            check("retry period 2", rises[2] - rises[1], 36);
        end
        @(negedge refclk);
        clr_err = 1'b1;
        @(negedge refclk);
        clr_err = 1'b0;
        check("lock_err cleared", lock_err, 0);
        repeat (33) @(negedge refclk);
        clr_err = 1'b1;
        @(negedge refclk);
        clr_err = 1'b0;
        check("timeout with clear pll_rst", pll_rst, 1);
        check("timeout with clear lock_err", lock_err, 1);

        // Randomized lock runs, divisor changes and clears.
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge refclk);
            if (run_left == 0) begin
                pll_locked = ~pll_locked;
                run_left = pll_locked ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 45));
            end else begin
                run_left--;
            end
            if ($urandom_range(0, 39) == 0) div = 8'($urandom);
            clr_err = ($urandom_range(0, 29) == 0);
        end
        clr_err = 1'b0;

        // 300 forced lock losses drive relock_cnt into saturation.
        div = {4'd1, 4'd2};
        for (int n = 0; n < 300; n++) begin
            pll_locked = 1'b1;
            ok = 1'b0;
            for (int j = 0; j < 60; j++) begin
                @(negedge refclk);
                if (locked) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                check("relock within budget", locked, 1);
                break;
            end
            pll_locked = 1'b0;
            repeat (3) @(negedge refclk);
        end
        pll_locked = 1'b1;
        for (int j = 0; j < 60; j++) begin
            @(negedge refclk);
            if (locked) break;
        end
        check("saturated locked", locked, 1);
        check("saturated relock_cnt", relock_cnt, RELOCK_SAT);

        // Asynchronous reset in the middle of a cycle while running.
        @(posedge refclk);
        #3 rst = 1'b0;
        #1;
        check("async pll_rst", pll_rst, 1);
        check("async locked", locked, 0);
        check("async rst_out_n", rst_out_n, 0);
        check("async clk_en", clk_en, 0);
        check("async relock_cnt", relock_cnt, 0);
        check("async lock_err", lock_err, 0);
        repeat (3) @(negedge refclk);
        rst = 1'b1;
        repeat (30) @(negedge refclk);
        check("final locked", locked, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_clk_manager.md
PLL_CLK_MANAGER -- requirements
Module: pll_clk_manager

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of clock-enable channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 8, width of each channel divisor.
REQ-003 SHALL have parameter RST_PULSE, default 16, number of refclk cycles that pll_rst is held high per PLL reset.
REQ-004 SHALL have parameter LOCK_STABLE, default 256, number of consecutive synchronised-locked cycles required before run.
REQ-005 SHALL have parameter LOCK_TIMEOUT, default 65536, number of cycles allowed in WAIT_LOCK before the PLL is reset again.
REQ-006 SHALL have parameter CNT_W, default 8, width of relock_cnt.
REQ-007 SHALL have port refclk, input, 1, the single clock for all logic.
REQ-008 SHALL have port rst, input, 1, with reset asynchronous and active-low.
REQ-009 SHALL have port pll_locked, input, 1, raw asynchronous lock flag from the PLL.
REQ-010 SHALL have port div, input, NUM_CH*DIV_W, per-channel divisor, with channel k in bits [k*DIV_W +: DIV_W].
REQ-011 SHALL have port clr_err, input, 1, a synchronous pulse that clears lock_err.
REQ-012 SHALL have port pll_rst, output, 1, active-high reset to the PLL.
REQ-013 SHALL have port locked, output, 1, qualified lock indication.
REQ-014 SHALL have port rst_out_n, output, 1, active-low reset to downstream logic.
REQ-015 SHALL have port clk_en, output, NUM_CH, per-channel single-cycle enable pulses.
REQ-016 SHALL have port relock_cnt, output, CNT_W, count of lock losses during run.
REQ-017 SHALL have port lock_err, output, 1, sticky flag for a lock timeout.

Function
REQ-018 SHALL synchronise pll_locked through two refclk flops (lk_s) before any use.
REQ-019 SHALL implement FSM states RESET_PLL, WAIT_LOCK, STABLE and RUN, with every output registered.
REQ-020 RESET_PLL SHALL hold pll_rst=1 for exactly RST_PULSE cycles, then go to WAIT_LOCK.
REQ-021 WAIT_LOCK SHALL go to STABLE when lk_s=1.
REQ-022 WAIT_LOCK SHALL go to RESET_PLL and set lock_err after LOCK_TIMEOUT cycles with lk_s=0.
REQ-023 STABLE SHALL go to RUN after LOCK_STABLE consecutive cycles with lk_s=1.
REQ-024 In STABLE, any cycle with lk_s=0 SHALL return the FSM to WAIT_LOCK with the timeout counter restarted.
REQ-025 In RUN, lk_s=0 SHALL move the FSM to RESET_PLL and increment relock_cnt, saturating at 2^CNT_W-1.
REQ-026 locked and rst_out_n SHALL be 1 only while in RUN, and both SHALL drop in the cycle the FSM leaves RUN.
REQ-027 Each channel SHALL have a counter that clears on RUN entry and counts 0..div_k.
- clk_en[k] pulses high for one cycle when the counter equals div_k, and the counter then wraps to 0.
- The period is div_k+1 cycles, and the first pulse occurs div_k+1 cycles after RUN entry.
- div_k=0 gives clk_en[k] constantly high in RUN.
REQ-028 div_k SHALL be captured into a shadow register at RUN entry and at each wrap of its counter, so a change mid-period never shortens or stretches the current period.
REQ-029 clk_en SHALL be all zero outside RUN.
REQ-030 lock_err SHALL clear on clr_err, and a timeout in the same cycle as clr_err SHALL leave lock_err set.
REQ-031 A pll_locked glitch shorter than one refclk cycle that is not captured by the synchroniser SHALL have no effect.

Reset
REQ-032 While rst=0: state is RESET_PLL, pll_rst=1, locked=0, rst_out_n=0, clk_en=0, relock_cnt=0, lock_err=0, and all counters and synchroniser flops are 0.
REQ-033 On rst deassertion, the module SHALL start a full RST_PULSE-cycle pll_rst pulse.
REQ-034 Assertion of rst mid-operation, in any state, SHALL force the REQ-032 values immediately, without waiting for refclk.

Verification (RST_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, NUM_CH=2, DIV_W=4)
REQ-035 The bench SHALL drive rst release with pll_locked=1 held and div={4'd3,4'd0} -> pll_rst high 4 cycles; locked=1 at 4+2+8 cycles (±1 for the FSM register); clk_en[0] constantly high; clk_en[1] pulsing every 4 cycles.
REQ-036 The bench SHALL hold pll_locked=0 -> pll_rst pulses of 4 cycles repeat every 36 cycles; lock_err=1 after the first timeout; clr_err clears it, and it re-sets at the next timeout.
REQ-037 The bench SHALL drop pll_locked for 3 cycles during RUN -> locked=0, rst_out_n=0, clk_en=0, relock_cnt=1, and a new 4-cycle pll_rst pulse occurs.
REQ-038 The bench SHALL drop pll_locked for one full cycle at count 5 in STABLE -> the FSM returns to WAIT_LOCK, and locked rises only after 8 fresh consecutive lock cycles.
REQ-039 The bench SHALL change div[7:4] from 3 to 1 mid-period -> the current 4-cycle period completes, then pulses every 2 cycles.
REQ-040 The bench SHALL force 300 lock losses with CNT_W=8 -> relock_cnt holds at 255, then asserting rst -> all outputs match REQ-032 values asynchronously.
